// File: rtl/ansi_term_pkg.sv
// Shared constants, FSM state type and small CSI helpers for the ANSI text terminal.
package ansi_term_pkg;

   localparam int         TERM_COLS    = 80;
   localparam int         TERM_ROWS    = 30;
   localparam logic [3:0] ATTR_DEFAULT = 4'h7;

   localparam logic [7:0] B_ESC      = 8'h1B;
   localparam logic [7:0] B_CSI_LB   = 8'h5B;
   localparam logic [7:0] B_CR       = 8'h0D;
   localparam logic [7:0] B_LF       = 8'h0A;
   localparam logic [7:0] B_BS       = 8'h08;
   localparam logic [7:0] B_ENTER_8D = 8'h8D;
   localparam logic [7:0] B_SEMI     = 8'h3B;
   localparam logic [7:0] B_SPACE    = 8'h20;
   localparam logic [7:0] B_SGR      = 8'h6D;
   localparam logic [7:0] B_CUP      = 8'h48;
   localparam logic [7:0] B_ED       = 8'h4A;
   localparam logic [7:0] B_EL       = 8'h4B;

   typedef enum logic [1:0] {NORMAL, ESC, CSI, FILL} term_state_t;

   function automatic logic [3:0] sgr_apply(input logic [3:0] attr, input logic [7:0] p);
      if (p == 8'd0) return ATTR_DEFAULT;
      if (p >= 8'd30 && p <= 8'd37) return 4'(p - 8'd30);
      return attr;
   endfunction

   // CUP coordinates are 1-based with 0 meaning 1; result is 0-based and clamped to lim.
   function automatic logic [7:0] cup_pos(input logic [7:0] p, input logic [7:0] lim);
      logic [7:0] v;
      v = (p == 8'd0) ? 8'd0 : p - 8'd1;
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/ansi_vram_writer_csi_param_acc.sv
// Two saturating decimal accumulators for CSI parameters, selected by a separator-driven index.
module csi_param_acc
   import ansi_term_pkg::*;
#(
   parameter int PARAM_MAX = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   input  logic       separator,
   output logic [7:0] p0,
   output logic [7:0] p1,
   output logic [1:0] idx
);

   function automatic logic [7:0] acc_step(input logic [7:0] p, input logic [3:0] d);
      logic [11:0] v;
      v = 12'(p) * 12'd10 + 12'(d);
      return (v > 12'(PARAM_MAX)) ? 8'(PARAM_MAX) : v[7:0];
   endfunction

   // Index 2 means "past the second parameter": further digits are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0  <= 8'd0;
         p1  <= 8'd0;
         idx <= 2'd0;
      end else if (clear) begin
         p0  <= 8'd0;
         p1  <= 8'd0;
         idx <= 2'd0;
      end else if (separator) begin
         if (idx != 2'd2) idx <= idx + 2'd1;
      end else if (digit_valid) begin
         if (idx == 2'd0)      p0 <= acc_step(p0, digit);
         else if (idx == 2'd1) p1 <= acc_step(p1, digit);
      end
   end

endmodule

// File: rtl/ansi_vram_writer.sv
// Cursor-driven 80x30 text terminal: decodes a byte stream (printables, controls, CSI)
// into charbuf port-A writes, with row/col-walking FILL for line advance, ED and EL.
module ansi_vram_writer
   import ansi_term_pkg::*;
#(
   parameter int COLS      = TERM_COLS,
   parameter int ROWS      = TERM_ROWS,
   parameter int ADDR_W    = 12,
   parameter int PARAM_MAX = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   input  logic [7:0]        i_data,
   output logic              o_ready,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_addr,
   output logic [7:0]        o_data,
   output logic [3:0]        o_attr,
   output logic [6:0]        o_cur_col,
   output logic [4:0]        o_cur_row
);

   localparam int FILL_W = 12;

   term_state_t       state, state_next;
   logic [6:0]        cur_col, col_n, fill_col, fill_col_n;
   logic [4:0]        cur_row, row_n, fill_row, fill_row_n, adv_row;
   logic [3:0]        attr, attr_n;
   logic [FILL_W-1:0] fill_cnt, fill_cnt_n;
   logic              we_n, line_adv;
   logic [ADDR_W-1:0] addr_n;
   logic [7:0]        data_n;
   logic              accept, is_print, is_digit, is_final;
   logic              acc_clear, acc_digit, acc_sep;
   logic [7:0]        p0, p1;
   logic [1:0]        pidx;

   assign accept   = i_valid & o_ready;
   assign is_print = (i_data >= 8'h20) && (i_data <= 8'h7E);
   assign is_digit = (i_data >= 8'h30) && (i_data <= 8'h39);
   assign is_final = (i_data >= 8'h40) && (i_data <= 8'h7E);

   csi_param_acc #(.PARAM_MAX(PARAM_MAX)) u_params (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (acc_clear),
      .digit_valid (acc_digit),
      .digit       (i_data[3:0]),
      .separator   (acc_sep),
      .p0          (p0),
      .p1          (p1),
      .idx         (pidx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= NORMAL;
      else        state <= state_next;
   end

   // Next-state and datapath decode; every FILL source just loads start point and count.
   always_comb begin
      state_next = state;
      col_n      = cur_col;
      row_n      = cur_row;
      attr_n     = attr;
      fill_row_n = fill_row;
      fill_col_n = fill_col;
      fill_cnt_n = fill_cnt;
      we_n       = 1'b0;
      addr_n     = o_addr;
      data_n     = o_data;
      acc_clear  = 1'b0;
      acc_digit  = 1'b0;
      acc_sep    = 1'b0;
      line_adv   = 1'b0;
      adv_row    = (cur_row == 5'(ROWS-1)) ? 5'd0 : cur_row + 5'd1;
      case (state)
         NORMAL: if (accept) begin
            if (is_print) begin
               we_n   = 1'b1;
               addr_n = ADDR_W'({cur_row, cur_col});
               data_n = i_data;
               if (cur_col == 7'(COLS-1)) begin
                  col_n    = 7'd0;
                  line_adv = 1'b1;
               end else begin
                  col_n = cur_col + 7'd1;
               end
            end else begin
               case (i_data)
                  B_CR:       col_n = 7'd0;
                  B_LF:       line_adv = 1'b1;
                  B_ENTER_8D: begin
                     col_n    = 7'd0;
                     line_adv = 1'b1;
                  end
                  B_BS:       if (cur_col != 7'd0) col_n = cur_col - 7'd1;
                  B_ESC:      state_next = ESC;
                  default:    ;
               endcase
            end
         end
         ESC: if (accept) begin
            if (i_data == B_CSI_LB) begin
               state_next = CSI;
               acc_clear  = 1'b1;
            end else if (i_data != B_ESC) begin
               state_next = NORMAL;
            end
         end
         CSI: if (accept) begin
            if (is_digit) begin
               acc_digit = 1'b1;
            end else if (i_data == B_SEMI) begin
               acc_sep = 1'b1;
            end else if (is_final) begin
               state_next = NORMAL;
               case (i_data)
                  B_SGR: attr_n = (pidx != 2'd0) ? sgr_apply(sgr_apply(attr, p0), p1)
                                                 : sgr_apply(attr, p0);
                  B_CUP: begin
                     row_n = 5'(cup_pos(p0, 8'(ROWS-1)));
                     col_n = 7'(cup_pos(p1, 8'(COLS-1)));
                  end
                  B_ED: if (p0 == 8'd2) begin
                     fill_row_n = 5'd0;
                     fill_col_n = 7'd0;
                     fill_cnt_n = FILL_W'(ROWS*COLS);
                     row_n      = 5'd0;
                     col_n      = 7'd0;
                     state_next = FILL;
                  end
                  B_EL: begin
                     fill_row_n = cur_row;
                     fill_col_n = cur_col;
                     fill_cnt_n = FILL_W'(COLS) - FILL_W'(cur_col);
                     state_next = FILL;
                  end
                  default: ;
               endcase
            end else if (i_data == B_ESC) begin
               state_next = ESC;
            end else begin
               state_next = NORMAL;
            end
         end
         FILL: begin
            we_n   = 1'b1;
            addr_n = ADDR_W'({fill_row, fill_col});
            data_n = B_SPACE;
            if (fill_col == 7'(COLS-1)) begin
               fill_col_n = 7'd0;
               fill_row_n = (fill_row == 5'(ROWS-1)) ? 5'd0 : fill_row + 5'd1;
            end else begin
               fill_col_n = fill_col + 7'd1;
            end
            fill_cnt_n = fill_cnt - FILL_W'(1);
            if (fill_cnt == FILL_W'(1)) state_next = NORMAL;
         end
      endcase
      if (line_adv) begin
         row_n      = adv_row;
         fill_row_n = adv_row;
         fill_col_n = 7'd0;
         fill_cnt_n = FILL_W'(COLS);
         state_next = FILL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_col  <= 7'd0;
         cur_row  <= 5'd0;
         attr     <= ATTR_DEFAULT;
         fill_row <= 5'd0;
         fill_col <= 7'd0;
         fill_cnt <= '0;
         o_we     <= 1'b0;
         o_addr   <= '0;
         o_data   <= 8'd0;
      end else begin
         cur_col  <= col_n;
         cur_row  <= row_n;
         attr     <= attr_n;
         fill_row <= fill_row_n;
         fill_col <= fill_col_n;
         fill_cnt <= fill_cnt_n;
         o_we     <= we_n;
         o_addr   <= addr_n;
         o_data   <= data_n;
      end
   end

   always_comb begin
      o_ready   = (state != FILL);
      o_attr    = attr;
      o_cur_col = cur_col;
      o_cur_row = cur_row;
   end

endmodule

// File: tb/tb_ansi_vram_writer.sv
// Bench for ansi_vram_writer: vector table, hand-written FILL/reset sequences and a
// randomized token stream compared against a screen-level model.
module tb_ansi_vram_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic [7:0]  i_data = 8'h00;
   logic        o_ready, o_we;
   logic [11:0] o_addr;
   logic [7:0]  o_data;
   logic [3:0]  o_attr;
   logic [6:0]  o_cur_col;
   logic [4:0]  o_cur_row;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ansi_vram_writer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_valid   (i_valid),
      .i_data    (i_data),
      .o_ready   (o_ready),
      .o_we      (o_we),
      .o_addr    (o_addr),
      .o_data    (o_data),
      .o_attr    (o_attr),
      .o_cur_col (o_cur_col),
      .o_cur_row (o_cur_row)
   );

   // Shadow of charbuf built from observed write pulses.
   int          wr_total = 0;
   logic [11:0] last_addr = '0;
   logic [7:0]  last_data = '0;
   logic [3:0]  last_attr = '0;
   logic [11:0] vram [4096];

   always @(negedge clk) begin
      if (rst_n && o_we) begin
         wr_total++;
         last_addr = o_addr;
         last_data = o_data;
         last_attr = o_attr;
         vram[o_addr] = {o_attr, o_data};
      end
   end

   // Screen-level reference model.
   logic [11:0] scr [30][80];
   int mcol, mrow, mattr;

   function automatic void m_advance();
      mrow = (mrow + 1) % 30;
      for (int c = 0; c < 80; c++) scr[mrow][c] = {4'(mattr), 8'h20};
   endfunction

   function automatic void m_print(input logic [7:0] ch);
      scr[mrow][mcol] = {4'(mattr), ch};
      if (mcol == 79) begin
         mcol = 0;
         m_advance();
      end else begin
         mcol++;
      end
   endfunction

   function automatic void m_sgr(input int v);
      int p;
      p = (v > 255) ? 255 : v;
      if (p == 0) mattr = 7;
      else if (p >= 30 && p <= 37) mattr = p - 30;
   endfunction

   function automatic int cup_model(input int v, input int n);
      int p;
      p = (v > 255) ? 255 : v;
      if (p < 1) p = 1;
      return (p > n) ? n - 1 : p - 1;
   endfunction

   function automatic logic [11:0] lin_addr(input int n);
      return {5'(n / 80), 7'(n % 80)};
   endfunction

   task automatic check_output(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      i_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic apply_stimulus(input logic [7:0] b);
      int guard;
      guard = 0;
      while (!o_ready && guard < 5000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!o_ready) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL ready_timeout: o_ready=0, expected 1");
      end
      i_valid = 1'b1;
      i_data  = b;
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) apply_stimulus(s[i]);
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (!o_ready && guard < 3000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!o_ready) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL idle_timeout: o_ready=0, expected 1");
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      string seq;
      int    col;
      int    row;
      int    attr;
      int    writes;
      int    addr;
      int    data;
      int    wattr;
   } vec_t;

   vec_t vecs[$];

   task automatic run_vector(input vec_t v, input int idx);
      int base;
      do_reset();
      base = wr_total;
      send_str(v.seq);
      wait_idle();
      check_output($sformatf("v%0d_col", idx), int'(o_cur_col), v.col);
      check_output($sformatf("v%0d_row", idx), int'(o_cur_row), v.row);
      check_output($sformatf("v%0d_attr", idx), int'(o_attr), v.attr);
      check_output($sformatf("v%0d_writes", idx), wr_total - base, v.writes);
      if (v.writes > 0) begin
         check_output($sformatf("v%0d_addr", idx), int'(last_addr), v.addr);
         check_output($sformatf("v%0d_data", idx), int'(last_data), v.data);
         check_output($sformatf("v%0d_wattr", idx), int'(last_attr), v.wattr);
      end
   endtask

   task automatic random_token();
      int k, a, b;
      logic [7:0] ch;
      k = $urandom_range(0, 99);
      if (k < 45) begin
         ch = 8'($urandom_range(32, 126));
         apply_stimulus(ch);
         m_print(ch);
      end else if (k < 50) begin
         apply_stimulus(8'h0D);
         mcol = 0;
      end else if (k < 54) begin
         apply_stimulus(8'h0A);
         m_advance();
      end else if (k < 57) begin
         apply_stimulus(8'h8D);
         mcol = 0;
         m_advance();
      end else if (k < 63) begin
         apply_stimulus(8'h08);
         if (mcol > 0) mcol--;
      end else if (k < 74) begin
         a = ($urandom_range(0, 9) < 2) ? 0 :
             ($urandom_range(0, 9) < 6) ? 30 + $urandom_range(0, 7) : $urandom_range(0, 400);
         b = ($urandom_range(0, 1) == 0) ? 30 + $urandom_range(0, 7) : $urandom_range(0, 300);
         if ($urandom_range(0, 1) == 0) begin
            send_str($sformatf("\033[%0dm", a));
            m_sgr(a);
         end else begin
            send_str($sformatf("\033[%0d;%0dm", a, b));
            m_sgr(a);
            m_sgr(b);
         end
      end else if (k < 82) begin
         a = ($urandom_range(0, 9) == 0) ? 300 : $urandom_range(0, 35);
         b = ($urandom_range(0, 9) == 0) ? 300 : $urandom_range(0, 90);
         send_str($sformatf("\033[%0d;%0dH", a, b));
         mrow = cup_model(a, 30);
         mcol = cup_model(b, 80);
      end else if (k < 87) begin
         send_str("\033[K");
         for (int c = mcol; c < 80; c++) scr[mrow][c] = {4'(mattr), 8'h20};
      end else if (k < 92) begin
         apply_stimulus(($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 7))
                                                   : 8'($urandom_range(8'h80, 8'h8C)));
      end else if (k < 96) begin
         send_str("\033x");
      end else begin
         send_str("\033[2!");
      end
   endtask

   initial begin
      int base, n, good, low, ready_hi, bad, first_bad;

      vecs.push_back('{"Hi",                    2,  0, 7, 2,  'h001, 'h69, 7});
      vecs.push_back('{"\033[31mA",             1,  0, 1, 1,  'h000, 'h41, 1});
      vecs.push_back('{"\033[31m\033[0mB",      1,  0, 7, 1,  'h000, 'h42, 7});
      vecs.push_back('{"\033[5;10HX",           10, 4, 7, 1,  'h209, 'h58, 7});
      vecs.push_back('{"\033[99;200H",          79, 29, 7, 0, 0, 0, 0});
      vecs.push_back('{"\033xQ",                1,  0, 7, 1,  'h000, 'h51, 7});
      vecs.push_back('{"\033[3!m",              1,  0, 7, 1,  'h000, 'h6D, 7});
      vecs.push_back('{"\033[32m\033[999m",     0,  0, 2, 0,  0, 0, 0});
      vecs.push_back('{"AB\010\010\010C",       1,  0, 7, 3,  'h000, 'h43, 7});
      vecs.push_back('{"abc\010\033[K",         2,  0, 7, 81, 'h04F, 'h20, 7});
      vecs.push_back('{"\n",                    0,  1, 7, 80, 'h0CF, 'h20, 7});
      vecs.push_back('{"xy\215",                0,  1, 7, 82, 'h0CF, 'h20, 7});
      vecs.push_back('{"\033[31;32;35mA",       1,  0, 2, 1,  'h000, 'h41, 2});
      vecs.push_back('{"\033\033[33mA",         1,  0, 3, 1,  'h000, 'h41, 3});
      vecs.push_back('{"\033[3\033[34mA",       1,  0, 4, 1,  'h000, 'h41, 4});
      vecs.push_back('{"ab\033[0;0H",           0,  0, 7, 2,  'h001, 'h62, 7});
      vecs.push_back('{"\033[37;30mA",          1,  0, 0, 1,  'h000, 'h41, 0});
      vecs.push_back('{"\033[36m\033[38m",      0,  0, 6, 0,  0, 0, 0});
      vecs.push_back('{"\033[3;4H\033[1K",      3,  2, 7, 77, 'h14F, 'h20, 7});
      vecs.push_back('{"\033[1J",               0,  0, 7, 0,  0, 0, 0});
      vecs.push_back('{"\033[5;5H\033[Z",       4,  4, 7, 0,  0, 0, 0});

      do_reset();
      check_output("rst_we",    int'(o_we), 0);
      check_output("rst_addr",  int'(o_addr), 0);
      check_output("rst_data",  int'(o_data), 0);
      check_output("rst_attr",  int'(o_attr), 7);
      check_output("rst_col",   int'(o_cur_col), 0);
      check_output("rst_row",   int'(o_cur_row), 0);
      check_output("rst_ready", int'(o_ready), 1);

      foreach (vecs[i]) run_vector(vecs[i], i);

      // 79 spaces then 'Z': Z lands in col 79, then an 80-cycle row fill of row 1.
      do_reset();
      for (int i = 0; i < 79; i++) apply_stimulus(8'h20);
      i_valid = 1'b1;
      i_data  = 8'h5A;
      @(posedge clk); #1;
      i_valid = 1'b0;
      check_output("wrap_z_write", int'({o_we, o_addr, o_data}), int'({1'b1, 12'h04F, 8'h5A}));
      low = 0;
      good = 0;
      for (int s = 0; s < 81; s++) begin
         if (!o_ready) low++;
         if (s >= 1 && o_we && o_addr == 12'(12'h080 + s - 1) && o_data == 8'h20) good++;
         @(posedge clk); #1;
      end
      check_output("wrap_ready_low", low, 80);
      check_output("wrap_fill_addrs", good, 80);
      check_output("wrap_we_end", int'(o_we), 0);
      check_output("wrap_col", int'(o_cur_col), 0);
      check_output("wrap_row", int'(o_cur_row), 1);

      // ESC[2J interrupted by reset at the 100th write.
      do_reset();
      send_str("\033[2J");
      n = 0;
      good = 0;
      ready_hi = 0;
      for (int s = 0; s < 3000 && n < 100; s++) begin
         if (o_ready) ready_hi++;
         if (o_we) begin
            if (o_addr == lin_addr(n) && o_data == 8'h20) good++;
            n++;
         end
         if (n < 100) begin
            @(posedge clk); #1;
         end
      end
      check_output("cls_writes_seen", n, 100);
      check_output("cls_addrs", good, 100);
      check_output("cls_ready_low", ready_hi, 0);
      rst_n = 1'b0;
      #1;
      check_output("cls_rst_we", int'(o_we), 0);
      check_output("cls_rst_ready", int'(o_ready), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      base = wr_total;
      repeat (5) begin
         @(posedge clk); #1;
      end
      check_output("cls_aborted", wr_total - base, 0);
      apply_stimulus(8'h51);
      wait_idle();
      check_output("cls_after_addr", int'(last_addr), 0);
      check_output("cls_after_col", int'(o_cur_col), 1);

      // Randomized token stream against the screen model, starting from a full clear.
      do_reset();
      base = wr_total;
      send_str("\033[2J");
      wait_idle();
      check_output("ed2_writes", wr_total - base, 2400);
      check_output("ed2_col", int'(o_cur_col), 0);
      check_output("ed2_row", int'(o_cur_row), 0);
      for (int r = 0; r < 30; r++)
         for (int c = 0; c < 80; c++) scr[r][c] = {4'h7, 8'h20};
      mcol = 0;
      mrow = 0;
      mattr = 7;
      for (int t = 0; t < 250; t++) begin
         random_token();
         wait_idle();
         check_output($sformatf("rnd%0d_col", t), int'(o_cur_col), mcol);
         check_output($sformatf("rnd%0d_row", t), int'(o_cur_row), mrow);
         check_output($sformatf("rnd%0d_attr", t), int'(o_attr), mattr);
      end
      bad = 0;
      first_bad = -1;
      for (int r = 0; r < 30; r++)
         for (int c = 0; c < 80; c++)
            if (vram[{5'(r), 7'(c)}] !== scr[r][c]) begin
               if (first_bad < 0) first_bad = r * 80 + c;
               bad++;
            end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("[TB] FAIL screen: %0d cells differ (first at row %0d col %0d), expected 0",
                  bad, first_bad / 80, first_bad % 80);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
